sdram_cmd_arbiter: RTL



---
 rtl/sdram_cmd_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - burst arbiter sharing the SDRAM command port between acquisition writes and TX reads
// Define SDRAM_ARB_STATS_EN to build the saturating issued-command counters.
module sdram_cmd_arbiter #(
  parameter int SDRAM_ADDRESS_WIDTH = 22,
  parameter int BURST_LEN           = 32
) (
  input  logic                           bb_clk,
  input  logic                           rst_n,
  input  logic                           aq_req,
  input  logic [SDRAM_ADDRESS_WIDTH-2:0] aq_addr,
  input  logic                           aq_urgent,
  output logic                           aq_ack,
  input  logic                           tx_req,
  input  logic [SDRAM_ADDRESS_WIDTH-2:0] tx_addr,
  output logic                           tx_ack,
  input  logic                           cmd_ready,
  output logic                           cmd_enable,
  output logic                           cmd_wr,
  output logic [SDRAM_ADDRESS_WIDTH-2:0] cmd_address,
  output logic [1:0]                     owner,
  output logic [15:0]                    aq_cmd_count,
  output logic [15:0]                    tx_cmd_count,
  input  logic                           stats_clr
);
  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    AQ_OWN = 2'b01,
    TX_OWN = 2'b10
  } state_t;

  state_t     state;
  logic [7:0] burst_cnt;
  logic       last_tx;
  logic       own_req;
  logic       urgent_aq;
  logic       can_issue;
  logic       burst_done;

  always_comb begin
    own_req    = (state == AQ_OWN) ? aq_req : tx_req;
    urgent_aq  = aq_urgent & aq_req;
    can_issue  = own_req & cmd_ready & ~cmd_enable;
    burst_done = (burst_cnt + 8'd1) == BURST_LAST;
  end

  assign owner = state;

  always_ff @(posedge bb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_cnt   <= 8'd0;
      last_tx     <= 1'b1;
      cmd_enable  <= 1'b0;
      cmd_wr      <= 1'b0;
      cmd_address <= '0;
      aq_ack      <= 1'b0;
      tx_ack      <= 1'b0;
    end else begin
      cmd_enable <= 1'b0;
      aq_ack     <= 1'b0;
      tx_ack     <= 1'b0;
      case (state)
        IDLE: begin
          burst_cnt <= 8'd0;
          if (urgent_aq)             state <= AQ_OWN;
          else if (aq_req && tx_req) state <= last_tx ? AQ_OWN : TX_OWN;
          else if (aq_req)           state <= AQ_OWN;
          else if (tx_req)           state <= TX_OWN;
        end
        AQ_OWN, TX_OWN: begin
          // An urgent acquisition only takes over between TX strobes, never mid-command.
          if (state == TX_OWN && urgent_aq && !cmd_enable) begin
            state   <= IDLE;
            last_tx <= 1'b1;
          end else if (can_issue) begin
            cmd_enable  <= 1'b1;
            cmd_wr      <= (state == AQ_OWN);
            cmd_address <= (state == AQ_OWN) ? aq_addr : tx_addr;
            aq_ack      <= (state == AQ_OWN);
            tx_ack      <= (state == TX_OWN);
            burst_cnt   <= burst_cnt + 8'd1;
            if (burst_done) begin
              state   <= IDLE;
              last_tx <= (state == TX_OWN);
            end
          end else if (!own_req && !cmd_enable) begin
            state   <= IDLE;
            last_tx <= (state == TX_OWN);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  always_ff @(posedge bb_clk or negedge rst_n) begin
    if (!rst_n) begin
      aq_cmd_count <= 16'd0;
      tx_cmd_count <= 16'd0;
    end else if (stats_clr) begin
      aq_cmd_count <= 16'd0;
      tx_cmd_count <= 16'd0;
    end else begin
      if (aq_ack && aq_cmd_count != 16'hFFFF) aq_cmd_count <= aq_cmd_count + 16'd1;
      if (tx_ack && tx_cmd_count != 16'hFFFF) tx_cmd_count <= tx_cmd_count + 16'd1;
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign aq_cmd_count     = 16'd0;
  assign tx_cmd_count     = 16'd0;
`endif
endmodule
